// File: rtl/eic_vectored_pkg.sv
// Shared constants and types for the vectored external interrupt controller.
// Register offsets within the controller's IO slot and the INR read layout.
package eic_vectored_pkg;

  // IO slot of the interrupt controller on the CPU IO bus
  localparam logic [2:0] EIC_ADDR = 3'h0;

  // Register offsets within the slot
  localparam logic [3:0] IER_ADDR = 4'h0;
  localparam logic [3:0] INR_ADDR = 4'h1;
  localparam logic [3:0] IPR_ADDR = 4'h2;
  localparam logic [3:0] ITR_ADDR = 4'h3;

  // Upper bound on the number of interrupt channels
  localparam int EIC_MAX_IRQ = 16;

  // Read layout of INR: in-service flag on top, channel index at the bottom
  typedef struct packed {
    logic        in_service;
    logic [14:0] reserved;
    logic [15:0] index;
  } inr_t;

endpackage

// File: rtl/eic_vectored_if.sv
// IO bus slave port of the interrupt controller.
// The CPU side uses the master modport, the controller the slave modport.
interface eic_vectored_if;
  logic        io_sel;
  logic [3:0]  io_addr;
  logic        io_wr_en;
  logic        io_rd_en;
  logic [31:0] io_wr_data;
  logic [31:0] io_rd_data;

  modport master (
    output io_sel, io_addr, io_wr_en, io_rd_en, io_wr_data,
    input  io_rd_data
  );

  modport slave (
    input  io_sel, io_addr, io_wr_en, io_rd_en, io_wr_data,
    output io_rd_data
  );
endinterface

// File: rtl/eic_vectored_prio_enc.sv
// Lowest-index-first priority encoder used to pick the interrupt winner.
module eic_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = IDX_W'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eic_vectored.sv
// Vectored external interrupt controller: NUM_IRQ channels with per-channel
// edge/level mode, pending register, fixed lowest-index priority and an
// acknowledge / end-of-interrupt handshake with the CPU.
// Optional: define EIC_SYNC_EN to pass each input through a 2-flop
// synchroniser before edge detection.
module eic_vectored
  import eic_vectored_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  eic_vectored_if.slave      bus,
  output logic               irq_req,
  input  logic               irq_ack
);

  logic [NUM_IRQ-1:0] ier, itr, ipr, prev, s, active, ipr_nxt;
  logic [NUM_IRQ-1:0] w1c_mask, mode_chg, ack_clr;
  logic [IDX_W-1:0]   inr_index, winner;
  logic               in_service, valid;
  logic               wr, rd, take, eoi;
  logic [31:0]        rd_val, rd_data;
  inr_t               inr_view;

`ifdef EIC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;

  // Two-flop synchroniser for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = irq_in;
`endif

  assign wr     = bus.io_sel & bus.io_wr_en;
  assign rd     = bus.io_sel & bus.io_rd_en;
  assign take   = irq_ack & irq_req;
  assign eoi    = wr && (bus.io_addr == INR_ADDR);
  assign active = ipr & ier;

  assign w1c_mask = (wr && bus.io_addr == IPR_ADDR) ? bus.io_wr_data[NUM_IRQ-1:0] : '0;
  assign mode_chg = (wr && bus.io_addr == ITR_ADDR) ? (bus.io_wr_data[NUM_IRQ-1:0] ^ itr) : '0;

  eic_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
    .req    (active),
    .winner (winner),
    .valid  (valid)
  );

  // Next pending state: edge channels latch rises with set-wins over clears,
  // level channels follow the line, and a mode change wipes the bit
  always_comb begin
    ack_clr = '0;
    ipr_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_clr[i] = take & valid & (winner == IDX_W'(i));
      if (itr[i]) begin
        ipr_nxt[i] = (s[i] & ~prev[i]) | (ipr[i] & ~(w1c_mask[i] | ack_clr[i]));
      end else begin
        ipr_nxt[i] = s[i];
      end
      if (mode_chg[i]) begin
        ipr_nxt[i] = 1'b0;
      end
    end
  end

  // Read mux; unmapped offsets and bits above NUM_IRQ read as zero
  always_comb begin
    inr_view            = '0;
    inr_view.in_service = in_service;
    inr_view.index      = 16'(inr_index);
    rd_val              = '0;
    case (bus.io_addr)
      IER_ADDR: rd_val[NUM_IRQ-1:0] = ier;
      INR_ADDR: rd_val = inr_view;
      IPR_ADDR: rd_val[NUM_IRQ-1:0] = ipr;
      ITR_ADDR: rd_val[NUM_IRQ-1:0] = itr;
      default:  rd_val = '0;
    endcase
  end

  // Register file, acknowledge / EOI handshake and the registered request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier        <= '0;
      itr        <= '0;
      ipr        <= '0;
      prev       <= '0;
      in_service <= 1'b0;
      inr_index  <= '0;
      irq_req    <= 1'b0;
      rd_data    <= '0;
    end else begin
      prev <= s;
      ipr  <= ipr_nxt;
      if (wr && bus.io_addr == IER_ADDR) ier <= bus.io_wr_data[NUM_IRQ-1:0];
      if (wr && bus.io_addr == ITR_ADDR) itr <= bus.io_wr_data[NUM_IRQ-1:0];
      if (eoi) in_service <= 1'b0;
      if (take) begin
        in_service <= 1'b1;
        inr_index  <= winner;
      end
      irq_req <= take ? 1'b0 : ((|active) & ~in_service);
      if (rd) rd_data <= rd_val;
    end
  end

  assign bus.io_rd_data = rd_data;

endmodule
